// File: rtl/mac_result_drain.sv
// Purpose: ping-pong buffers whole MAC result matrices and streams them out one row per beat.
// Latency: a capture into an idle drain shows row 0 on row_data the next cycle; ROWS beats per matrix minimum.
// Backpressure: row_ready low freezes the current beat; a capture arriving with both banks occupied is dropped and flagged.
module mac_result_drain #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            capture_en,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] pe_array_in,
    output logic [COLS*DATA_WIDTH-1:0]      row_data,
    output logic                            row_valid,
    input  logic                            row_ready,
    output logic [IDX_W-1:0]                row_idx,
    output logic                            row_last,
    output logic                            busy,
    output logic                            capture_drop
);

    localparam int ROW_W = COLS * DATA_WIDTH;
    localparam int MAT_W = ROWS * ROW_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic               rd_bank;
    logic               wr_bank;
    logic [1:0]         full;
    logic               drop_q;
    logic [MAT_W-1:0]   bank0;
    logic [MAT_W-1:0]   bank1;
    logic [MAT_W-1:0]   sel_mat;

    logic               hs;
    logic               row_done;
    logic               accept;
    logic [1:0]         full_nxt;

    // Handshake, bank release and capture acceptance; a bank freed on this edge may be refilled on the same edge.
    always_comb begin
        hs       = (state == DRAIN) && row_ready;
        row_done = hs && (cnt == LAST_IDX);
        accept   = capture_en && (!full[wr_bank] || (row_done && (rd_bank == wr_bank)));
        full_nxt = full;
        if (row_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (accept) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Matrix storage: only accepted captures load a bank; contents are never visible unless the bank is full.
    always_ff @(posedge clk) begin
        if (accept && !wr_bank) begin
            bank0 <= pe_array_in;
        end
        if (accept && wr_bank) begin
            bank1 <= pe_array_in;
        end
    end

    // Bank bookkeeping, drop flag and drain FSM; IDLE looks at next-state fullness to hit one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_bank <= 1'b0;
            wr_bank <= 1'b0;
            full    <= 2'b00;
            drop_q  <= 1'b0;
        end else begin
            full   <= full_nxt;
            drop_q <= capture_en && !accept;
            if (accept) begin
                wr_bank <= ~wr_bank;
            end
            case (state)
                IDLE: begin
                    if (full_nxt[rd_bank]) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (row_done) begin
                        rd_bank <= ~rd_bank;
                        cnt     <= '0;
                        state   <= full_nxt[~rd_bank] ? DRAIN : IDLE;
                    end else if (hs) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output view: row selected from the draining bank, forced to zero when no beat is offered.
    always_comb begin
        sel_mat      = rd_bank ? bank1 : bank0;
        row_valid    = (state == DRAIN);
        row_data     = row_valid ? sel_mat[cnt*ROW_W +: ROW_W] : '0;
        row_idx      = cnt;
        row_last     = row_valid && (cnt == LAST_IDX);
        busy         = |full;
        capture_drop = drop_q;
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Purpose: directed check of mac_result_drain: single drain, stalls, ping-pong, overflow, same-edge refill, reset.
// Latency: expects row 0 on the cycle after a capture into an idle drain.
// Backpressure: drives row_ready constant or pseudo-random and requires frozen beats while stalled.
module tb_mac_result_drain;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int DW    = 16;
    localparam int ROW_W = COLS * DW;
    localparam int MAT_W = ROWS * ROW_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             capture_en = 1'b0;
    logic [MAT_W-1:0] pe_array_in = '0;
    logic [ROW_W-1:0] row_data;
    logic             row_valid;
    logic             row_ready = 1'b0;
    logic [3:0]       row_idx;
    logic             row_last;
    logic             busy;
    logic             capture_drop;

    int checks = 0;
    int errors = 0;

    logic [ROW_W-1:0] exp_q[$];
    int               exp_r[$];

    typedef struct {
        logic             ready;
        logic             valid;
        logic [3:0]       idx;
        logic             last;
        logic             busy;
        logic [ROW_W-1:0] data;
    } vec_t;

    vec_t tv[17];

    mac_result_drain #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .IDX_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_en   (capture_en),
        .pe_array_in  (pe_array_in),
        .row_data     (row_data),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_idx      (row_idx),
        .row_last     (row_last),
        .busy         (busy),
        .capture_drop (capture_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [MAT_W-1:0] mat_seq();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[(r*COLS+c)*DW +: DW] = 16'(r*COLS + c);
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] mat_fill(input logic [15:0] v);
        return {(ROWS*COLS){v}};
    endfunction

    function automatic logic [MAT_W-1:0] mat_rand();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < ROWS*COLS; i++)
            m[i*DW +: DW] = 16'($urandom);
        return m;
    endfunction

    task automatic push_mat(input logic [MAT_W-1:0] m);
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back(m[r*ROW_W +: ROW_W]);
            exp_r.push_back(r);
        end
    endtask

    // One capture pulse with ready untouched; reports capture_drop on the two following cycles.
    task automatic cap(input logic [MAT_W-1:0] m, output logic d1, output logic d2);
        @(negedge clk);
        capture_en  = 1'b1;
        pe_array_in = m;
        @(negedge clk);
        capture_en  = 1'b0;
        pe_array_in = ~m;
        d1 = capture_drop;
        @(negedge clk);
        d2 = capture_drop;
    endtask

    // Accept n beats against the expected queue; optional capture injected at cycle cap_at.
    task automatic collect(input int n, input bit rnd, input int cap_at, input logic [MAT_W-1:0] cap_mat,
                           input int budget, output int gaps, output int drops);
        int               got;
        bit               started;
        bit               prev_stall;
        bit               r;
        logic [ROW_W-1:0] pd;
        logic [3:0]       pi;
        logic [ROW_W-1:0] ed;
        int               er;
        got = 0; started = 0; prev_stall = 0; gaps = 0; drops = 0;
        pd = '0; pi = '0;
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            if (capture_drop) drops++;
            if (prev_stall) begin
                check("stall_valid", ROW_W'(row_valid), ROW_W'(1));
                check("stall_data", row_data, pd);
                check("stall_idx", ROW_W'(row_idx), ROW_W'(pi));
            end
            if (started && !row_valid) gaps++;
            if (row_valid) started = 1;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            row_ready   = r;
            capture_en  = (k == cap_at);
            pe_array_in = (k == cap_at) ? cap_mat : {(MAT_W/32){32'(k) * 32'h9E3779B9}};
            if (row_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", ROW_W'(1), ROW_W'(0));
                end else begin
                    ed = exp_q.pop_front();
                    er = exp_r.pop_front();
                    check("beat_data", row_data, ed);
                    check("beat_idx", ROW_W'(row_idx), ROW_W'(er));
                    check("beat_last", ROW_W'(row_last), ROW_W'(er == ROWS-1));
                end
                got++;
            end
            prev_stall = row_valid && !r;
            pd = row_data;
            pi = row_idx;
        end
        if (got < n) check("beat_timeout", ROW_W'(got), ROW_W'(n));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        row_ready  = 1'b0;
        capture_en = 1'b0;
        check({tag, "_valid_after"}, ROW_W'(row_valid), ROW_W'(0));
        check({tag, "_busy_after"}, ROW_W'(busy), ROW_W'(0));
        check({tag, "_queue_empty"}, ROW_W'(exp_q.size()), ROW_W'(0));
    endtask

    initial begin
        logic [MAT_W-1:0] ma, mb, mc, mseq;
        logic d1, d2;
        int gaps, drops, seed;
        seed = $urandom(32'hC0FFEE);

        // Reset state
        #22;
        check("rst_valid", ROW_W'(row_valid), ROW_W'(0));
        check("rst_data", row_data, '0);
        check("rst_idx", ROW_W'(row_idx), ROW_W'(0));
        check("rst_last", ROW_W'(row_last), ROW_W'(0));
        check("rst_busy", ROW_W'(busy), ROW_W'(0));
        check("rst_drop", ROW_W'(capture_drop), ROW_W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single matrix, table-driven per-cycle expectations
        mseq = mat_seq();
        for (int k = 0; k < ROWS; k++)
            tv[k] = '{1'b1, 1'b1, 4'(k), (k == ROWS-1), 1'b1, mseq[k*ROW_W +: ROW_W]};
        tv[16] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, '0};
        capture_en  = 1'b1;
        pe_array_in = mseq;
        row_ready   = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            capture_en  = 1'b0;
            pe_array_in = ~mseq;
            check("t1_valid", ROW_W'(row_valid), ROW_W'(tv[k].valid));
            check("t1_idx", ROW_W'(row_idx), ROW_W'(tv[k].idx));
            check("t1_last", ROW_W'(row_last), ROW_W'(tv[k].last));
            check("t1_busy", ROW_W'(busy), ROW_W'(tv[k].busy));
            check("t1_data", row_data, tv[k].data);
            row_ready = tv[k].ready;
        end
        row_ready = 1'b0;

        // Backpressure with pseudo-random ready
        ma = mat_rand();
        push_mat(ma);
        @(negedge clk);
        capture_en  = 1'b1;
        pe_array_in = ma;
        collect(16, 1'b1, -1, '0, 400, gaps, drops);
        expect_idle("bp");

        // Ping-pong: B captured three cycles after A
        ma = mat_fill(16'h1111);
        mb = mat_fill(16'h2222);
        push_mat(ma);
        push_mat(mb);
        capture_en  = 1'b1;
        pe_array_in = ma;
        collect(32, 1'b0, 2, mb, 100, gaps, drops);
        check("pp_gaps", ROW_W'(gaps), ROW_W'(0));
        check("pp_drops", ROW_W'(drops), ROW_W'(0));
        expect_idle("pp");

        // Overflow: third capture with both banks held
        ma = mat_rand();
        mb = mat_rand();
        mc = mat_rand();
        cap(ma, d1, d2);
        check("ov_dropA", ROW_W'(d1), ROW_W'(0));
        cap(mb, d1, d2);
        check("ov_dropB", ROW_W'(d1), ROW_W'(0));
        cap(mc, d1, d2);
        check("ov_dropC", ROW_W'(d1), ROW_W'(1));
        check("ov_drop_pulse", ROW_W'(d2), ROW_W'(0));
        push_mat(ma);
        push_mat(mb);
        collect(32, 1'b0, -1, '0, 100, gaps, drops);
        check("ov_gaps", ROW_W'(gaps), ROW_W'(0));
        expect_idle("ov");

        // Capture on the same edge as the last-row release of A
        ma = mat_rand();
        mb = mat_rand();
        mc = mat_rand();
        cap(ma, d1, d2);
        cap(mb, d1, d2);
        check("sim_dropB", ROW_W'(d1), ROW_W'(0));
        push_mat(ma);
        push_mat(mb);
        push_mat(mc);
        collect(48, 1'b0, 15, mc, 200, gaps, drops);
        check("sim_drops", ROW_W'(drops), ROW_W'(0));
        check("sim_gaps", ROW_W'(gaps), ROW_W'(0));
        expect_idle("sim");

        // Reset in the middle of a drain
        ma = mat_rand();
        push_mat(ma);
        capture_en  = 1'b1;
        pe_array_in = ma;
        collect(7, 1'b0, -1, '0, 50, gaps, drops);
        @(negedge clk);
        check("rm_idx7", ROW_W'(row_idx), ROW_W'(7));
        check("rm_valid7", ROW_W'(row_valid), ROW_W'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rm_valid", ROW_W'(row_valid), ROW_W'(0));
        check("rm_data", row_data, '0);
        check("rm_idx", ROW_W'(row_idx), ROW_W'(0));
        check("rm_last", ROW_W'(row_last), ROW_W'(0));
        check("rm_busy", ROW_W'(busy), ROW_W'(0));
        exp_q.delete();
        exp_r.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        row_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rm_quiet_valid", ROW_W'(row_valid), ROW_W'(0));
            check("rm_quiet_busy", ROW_W'(busy), ROW_W'(0));
        end
        mseq = mat_seq();
        push_mat(mseq);
        capture_en  = 1'b1;
        pe_array_in = mseq;
        collect(16, 1'b0, -1, '0, 50, gaps, drops);
        expect_idle("rm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
